// File: rtl/irq_arbiter_gen_if.sv
// CPU-side grant handshake of the interrupt arbiter.
// The arbiter (master) presents a grant and holds it until the CPU (slave) acks it.
interface irq_arbiter_gen_if #(
  parameter int NUM_CH = 8,
  parameter int ID_W   = $clog2(NUM_CH)
);
  logic              irq_valid;
  logic [ID_W-1:0]   irq_id;
  logic [NUM_CH-1:0] irq_onehot;
  logic              irq_ack;

  modport master (
    output irq_valid,
    output irq_id,
    output irq_onehot,
    input  irq_ack
  );

  modport slave (
    input  irq_valid,
    input  irq_id,
    input  irq_onehot,
    output irq_ack
  );
endinterface

// File: rtl/irq_arbiter_gen.sv
// Parametrised interrupt arbiter.
// Per-channel priority, mask and edge/level trigger; priority or round-robin
// selection; a grant is held on the CPU interface until it is acknowledged.
module irq_arbiter_gen #(
  parameter int NUM_CH = 8,
  parameter int PRIO_W = 3,
  parameter int ID_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,        // active-low, asynchronous
  input  logic [NUM_CH-1:0]        irq_in,
  input  logic                     mode,       // 0 = priority, 1 = round-robin
  input  logic                     cfg_we,
  input  logic [NUM_CH*PRIO_W-1:0] cfg_prio,
  input  logic [NUM_CH-1:0]        mask,
  input  logic [NUM_CH-1:0]        edge_sel,
  irq_arbiter_gen_if.master        cpu,
  output logic [NUM_CH-1:0]        pending
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_valid;
  logic                w_valid_next;
  logic [ID_W-1:0]     r_id;
  logic [ID_W-1:0]     w_id_next;
  logic [NUM_CH-1:0]   r_onehot;
  logic [NUM_CH-1:0]   w_onehot_next;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     w_rr_next;

  logic [NUM_CH-1:0]   r_irq_d;       // previous-cycle sample for edge detection
  logic [NUM_CH-1:0]   r_pending;
  logic [NUM_CH-1:0]   w_pend_next;
  logic [NUM_CH-1:0]   w_rise;
  logic [NUM_CH-1:0]   w_clr;
  logic [NUM_CH-1:0]   w_elig;
  logic                w_ack_grant;

  logic [PRIO_W-1:0]   r_prio [NUM_CH];

  logic                w_pr_found;
  logic [ID_W-1:0]     w_pr_id;
  logic [PRIO_W-1:0]   w_pr_best;
  logic                w_rr_found;
  logic [ID_W-1:0]     w_rr_id;
  int                  w_rr_idx;

  // An ack only counts while a grant is outstanding; acks in IDLE are ignored.
  assign w_ack_grant = (r_state == GRANT) && cpu.irq_ack;
  assign w_elig      = r_pending & ~mask;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Edge channels latch a rising edge until acked (a new edge beats the clear);
      // level channels simply mirror the input one cycle late.
      assign w_rise[gi]      = irq_in[gi] & ~r_irq_d[gi];
      assign w_clr[gi]       = w_ack_grant & r_onehot[gi];
      assign w_pend_next[gi] = edge_sel[gi] ? (w_rise[gi] | (r_pending[gi] & ~w_clr[gi]))
                                            : irq_in[gi];

      // Per-channel priority register, writable at any time; only read at arbitration.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_prio[gi] <= '0;
        end else if (cfg_we) begin
          r_prio[gi] <= cfg_prio[gi*PRIO_W +: PRIO_W];
        end
      end
    end
  endgenerate

  // Edge history and pending vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq_d   <= '0;
      r_pending <= '0;
    end else begin
      r_irq_d   <= irq_in;
      r_pending <= w_pend_next;
    end
  end

  // Priority winner: strictly greater replaces, so ties keep the lowest index.
  always_comb begin
    w_pr_found = 1'b0;
    w_pr_id    = '0;
    w_pr_best  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_elig[i] && (!w_pr_found || (r_prio[i] > w_pr_best))) begin
        w_pr_found = 1'b1;
        w_pr_id    = ID_W'(i);
        w_pr_best  = r_prio[i];
      end
    end
  end

  // Round-robin winner: first eligible channel at or after rr_ptr, wrapping.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_id    = '0;
    w_rr_idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_rr_idx = int'(r_rr_ptr) + k;
      if (w_rr_idx >= NUM_CH) begin
        w_rr_idx = w_rr_idx - NUM_CH;
      end
      if (!w_rr_found && w_elig[w_rr_idx]) begin
        w_rr_found = 1'b1;
        w_rr_id    = ID_W'(w_rr_idx);
      end
    end
  end

  // Grant FSM: issue in IDLE, hold everything in GRANT until ack.
  always_comb begin
    w_state_next  = r_state;
    w_valid_next  = r_valid;
    w_id_next     = r_id;
    w_onehot_next = r_onehot;
    w_rr_next     = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (|w_elig) begin
          w_valid_next  = 1'b1;
          w_id_next     = mode ? w_rr_id : w_pr_id;
          w_onehot_next = NUM_CH'(1) << w_id_next;
          w_state_next  = GRANT;
        end
      end
      GRANT: begin
        if (cpu.irq_ack) begin
          w_valid_next  = 1'b0;
          w_onehot_next = '0;
          w_rr_next     = (r_id == ID_W'(NUM_CH - 1)) ? '0 : r_id + 1'b1;
          w_state_next  = IDLE;
        end
      end
      default: begin
        w_state_next  = IDLE;
        w_valid_next  = 1'b0;
        w_onehot_next = '0;
      end
    endcase
  end

  // FSM state and registered grant outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_onehot <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_next;
      r_valid  <= w_valid_next;
      r_id     <= w_id_next;
      r_onehot <= w_onehot_next;
      r_rr_ptr <= w_rr_next;
    end
  end

  assign cpu.irq_valid  = r_valid;
  assign cpu.irq_id     = r_id;
  assign cpu.irq_onehot = r_onehot;
  assign pending        = r_pending;

endmodule

// File: doc/irq_arbiter_gen.md
Name: irq_arbiter_gen

Overview:
- Parametrised interrupt controller; the next generation of the 4-input priority/polling controller.
- Adds N channels, per-channel programmable priority, per-channel mask, per-channel edge/level trigger and latched pending bits.
- Adds fair round-robin in place of the stall-on-active poller, plus a valid/ack handshake to the CPU side.
- Sits between peripheral interrupt lines and the core's interrupt-entry logic.

Parameters:
NUM_CH, 8, number of interrupt channels (2..32)
PRIO_W, 3, width of each channel's priority field
ID_W, $clog2(NUM_CH), width of the granted channel index

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous reset, active-low (asserted when 0)
irq_in  input  NUM_CH  raw interrupt requests, already synchronous to clk
mode  input  1  0 = priority arbitration, 1 = round-robin
cfg_we  input  1  load cfg_prio into the priority registers
cfg_prio  input  NUM_CH*PRIO_W  channel i priority = bits [i*PRIO_W +: PRIO_W]
mask  input  NUM_CH  1 = channel excluded from arbitration
edge_sel  input  NUM_CH  1 = rising-edge triggered, 0 = level
irq_valid  output  1  grant pending for the CPU
irq_id  output  ID_W  index of the granted channel
irq_onehot  output  NUM_CH  one-hot form of irq_id, 0 when not valid
irq_ack  input  1  CPU accepts the current grant
pending  output  NUM_CH  current pending vector, for status reads

Behaviour:
- Reset (rst=0, asynchronous):
  - irq_valid=0, irq_id=0, irq_onehot=0, pending=0.
  - Priority registers cleared to 0, rr_ptr=0, edge history register=0, FSM to IDLE.
  - Release is sampled on the next posedge.
- Priority registers:
  - Updated on the posedge where cfg_we=1; writes are allowed in any state.
  - A new value takes effect at the next arbitration; it never alters a grant already issued.
- Pending, edge channel: set when irq_in[i]=1 and the previous-cycle sample was 0. Cleared on the ack cycle when i is the granted id. If set and clear hit the same cycle, set wins.
- Pending, level channel: pending[i] mirrors irq_in[i] registered one cycle; it is never latched. Ack clears nothing.
- Eligible vector = pending & ~mask. Masking never clears pending.
- FSM state IDLE:
  - If the eligible vector is nonzero, compute the winner, register irq_id/irq_onehot, assert irq_valid and go to GRANT.
  - Otherwise stay in IDLE.
- FSM state GRANT:
  - Hold irq_valid, irq_id and irq_onehot stable until irq_ack=1.
  - On ack: drop irq_valid, set rr_ptr = (irq_id+1) mod NUM_CH, go to IDLE.
  - A grant is never revoked by a mask change, a level input dropping, a mode change or cfg_we.
- irq_ack while in IDLE: ignored.
- Priority mode: the eligible channel with the highest priority value wins. Ties go to the lowest index.
- Round-robin mode:
  - The first eligible channel scanning upward from rr_ptr wins, with wrap-around from NUM_CH-1 to 0.
  - rr_ptr also advances on acks made in priority mode; the value is kept across mode switches.
- Latency and throughput:
  - Edge input to pending: 1 cycle.
  - Pending to irq_valid: 1 cycle.
  - Rising edge on irq_in at posedge t gives irq_valid=1 after posedge t+2.
  - After an ack there is at least one IDLE cycle, so back-to-back grants are 2 cycles apart when ack is immediate.
- Level channel still asserted after ack: it re-arbitrates normally and may be granted again, subject to mode fairness.
- Reset asserted mid-GRANT: outputs clear immediately, without waiting for a clock edge; all pending bits are lost.

Test Plan:
- Reset: hold rst=0, drive irq_in=8'hFF -> irq_valid=0, pending=0. Release rst, all level -> irq_valid=1 two posedges later, irq_id=0 (all priorities 0, lowest index wins).
- Priority: mode=0, cfg_prio ch3=5, ch6=7, ch1=7, level irq_in=8'b0100_1010 -> grant order with immediate acks is 1, 1, 1... Drop ch1 -> 6. Drop ch6 -> 3.
- Round-robin: mode=1, irq_in=8'hFF level, ack every grant -> irq_id sequence 0,1,...,7,0. Consecutive irq_valid rises are 2 cycles apart.
- Edge latch and mask: edge_sel=8'hFF, mask[2]=1, one-cycle pulse on irq_in[2] -> pending[2]=1, no grant. Clear mask[2] -> grant id 2. Ack -> pending[2]=0 and no re-grant.
- Set/clear collision: edge ch4 granted, new rising edge on ch4 in the ack cycle -> pending[4] stays 1, ch4 granted again.
- Async reset mid-GRANT: irq_valid=1, id=5; pull rst low between clock edges -> irq_valid, irq_onehot and pending go to 0 before the next posedge.
